// File: rtl/lagarto0_pkg.sv
// Shared lagarto0 core parameters and types.
// Holds the L1 icache geometry and its refill state encoding.
package lagarto0_pkg;

  localparam int unsigned ADDR_SIZE        = 40;
  localparam int unsigned ICACHE_LINE_SIZE = 128;
  localparam int unsigned ICACHE_SETS      = 64;
  localparam int unsigned ICACHE_MEM_W     = 64;

  typedef enum logic [1:0] {
    IDLE,
    MISS_REQ,
    REFILL
  } icache_state_t;

  function automatic int unsigned clog2_min1(
    input int unsigned v
  );
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/icache_l1_refill_fsm.sv
// Icache refill FSM: state, beat counter, drop flag, line buffer.
// Ports: miss/miss_addr in, flush, mem handshake, fill strobe+line out.
module icache_refill_fsm
  import lagarto0_pkg::*;
#(
  parameter int unsigned MEM_DATA_W = ICACHE_MEM_W
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        miss,
  input  logic [ADDR_SIZE-1:0]        miss_addr,
  input  logic                        flush,
  input  logic                        mem_gnt,
  input  logic                        mem_rvalid,
  input  logic [MEM_DATA_W-1:0]       mem_data,
  output logic                        busy,
  output logic                        mem_req,
  output logic [ADDR_SIZE-1:0]        mem_addr,
  output logic                        fill,
  output logic                        fill_valid,
  output logic [ICACHE_LINE_SIZE-1:0] fill_line
);

  localparam int unsigned BEATS = ICACHE_LINE_SIZE / MEM_DATA_W;
  localparam int unsigned CNT_W = clog2_min1(BEATS);

  icache_state_t               state_q, state_d;
  logic [CNT_W-1:0]            cnt_q;
  logic                        drop_q;
  logic [ICACHE_LINE_SIZE-1:0] line_q;
  logic [ADDR_SIZE-1:0]        addr_q;
  logic                        beat;
  logic                        last;

  assign beat = (state_q == REFILL) & mem_rvalid;
  assign last = beat & (cnt_q == CNT_W'(BEATS - 1));

  // Current beat merged in so the last beat is installed the same edge.
  always_comb begin
    fill_line = line_q;
    fill_line[cnt_q*MEM_DATA_W +: MEM_DATA_W] = mem_data;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (miss) state_d = MISS_REQ;
      MISS_REQ: if (mem_gnt) state_d = REFILL;
      REFILL:   if (last) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && miss) begin
        addr_q <= miss_addr;
        drop_q <= 1'b0;
        cnt_q  <= '0;
      end
      if ((state_q != IDLE) && flush) begin
        drop_q <= 1'b1;
      end
      if (beat) begin
        line_q <= fill_line;
        cnt_q  <= last ? '0 : cnt_q + 1'b1;
      end
    end
  end

  assign busy       = (state_q != IDLE);
  assign mem_req    = (state_q == MISS_REQ);
  assign mem_addr   = addr_q;
  assign fill       = last;
  // A flush on the last beat also wins over the install.
  assign fill_valid = last & ~drop_q & ~flush;

endmodule

// File: rtl/icache_l1.sv
// Direct-mapped L1 icache, combinational lookup, flop arrays.
// Ports: req/pc lookup, flush, inst/hit/busy, mem refill bus; ICACHE_PERF_EN adds counters.
module icache_l1
  import lagarto0_pkg::*;
#(
  parameter int unsigned NUM_SETS   = ICACHE_SETS,
  parameter int unsigned MEM_DATA_W = ICACHE_MEM_W
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_i,
  input  logic [ADDR_SIZE-1:0]        pc_i,
  input  logic                        flush_i,
  output logic [ICACHE_LINE_SIZE-1:0] inst_o,
  output logic                        hit_o,
  output logic                        busy_o,
  output logic                        mem_req_o,
  output logic [ADDR_SIZE-1:0]        mem_addr_o,
  input  logic                        mem_gnt_i,
  input  logic                        mem_rvalid_i,
  input  logic [MEM_DATA_W-1:0]       mem_data_i
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]                 hit_cnt_o,
  output logic [31:0]                 miss_cnt_o
`endif
);

  localparam int unsigned OFF = $clog2(ICACHE_LINE_SIZE / 8);
  localparam int unsigned IDX = $clog2(NUM_SETS);
  localparam int unsigned TAG = ADDR_SIZE - IDX - OFF;

  logic [NUM_SETS-1:0]         valid_q;
  logic [TAG-1:0]              tag_q  [NUM_SETS];
  logic [ICACHE_LINE_SIZE-1:0] data_q [NUM_SETS];

  logic [IDX-1:0]              idx;
  logic [TAG-1:0]              tag;
  logic [IDX-1:0]              fidx;
  logic [TAG-1:0]              ftag;
  logic                        line_hit;
  logic                        busy;
  logic                        miss;
  logic                        fill;
  logic                        fill_valid;
  logic [ICACHE_LINE_SIZE-1:0] fill_line;
  logic [ADDR_SIZE-1:0]        miss_addr;
  logic                        unused_off;

  assign idx  = pc_i[OFF+IDX-1:OFF];
  assign tag  = pc_i[ADDR_SIZE-1:OFF+IDX];
  assign fidx = mem_addr_o[OFF+IDX-1:OFF];
  assign ftag = mem_addr_o[ADDR_SIZE-1:OFF+IDX];
  assign unused_off = ^pc_i[OFF-1:0];

  assign line_hit  = valid_q[idx] & (tag_q[idx] == tag);
  assign hit_o     = req_i & line_hit & ~busy;
  assign miss      = req_i & ~line_hit & ~busy;
  assign miss_addr = {pc_i[ADDR_SIZE-1:OFF], {OFF{1'b0}}};
  assign inst_o    = valid_q[idx] ? data_q[idx] : '0;
  assign busy_o    = busy;

  icache_refill_fsm #(
    .MEM_DATA_W (MEM_DATA_W)
  ) u_refill (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .miss       (miss),
    .miss_addr  (miss_addr),
    .flush      (flush_i),
    .mem_gnt    (mem_gnt_i),
    .mem_rvalid (mem_rvalid_i),
    .mem_data   (mem_data_i),
    .busy       (busy),
    .mem_req    (mem_req_o),
    .mem_addr   (mem_addr_o),
    .fill       (fill),
    .fill_valid (fill_valid),
    .fill_line  (fill_line)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (fill_valid) begin
      valid_q[fidx] <= 1'b1;
    end
  end

  // Tag/data are written even for a dropped refill; valid gates them.
  always_ff @(posedge clk_i) begin
    if (fill) begin
      tag_q[fidx]  <= ftag;
      data_q[fidx] <= fill_line;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_o && (hit_cnt_q != '1)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (miss && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_l1.sv
// Directed self-checking bench for icache_l1 (128-bit line, 64-bit beats).
// Build with ICACHE_PERF_EN to also cover the counters.
module tb_icache_l1;
  import lagarto0_pkg::*;

  logic                        clk_i = 1'b0;
  logic                        rst_ni;
  logic                        req_i;
  logic [ADDR_SIZE-1:0]        pc_i;
  logic                        flush_i;
  logic [ICACHE_LINE_SIZE-1:0] inst_o;
  logic                        hit_o;
  logic                        busy_o;
  logic                        mem_req_o;
  logic [ADDR_SIZE-1:0]        mem_addr_o;
  logic                        mem_gnt_i;
  logic                        mem_rvalid_i;
  logic [63:0]                 mem_data_i;
`ifdef ICACHE_PERF_EN
  logic [31:0]                 hit_cnt_o;
  logic [31:0]                 miss_cnt_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  icache_l1 dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .pc_i         (pc_i),
    .flush_i      (flush_i),
    .inst_o       (inst_o),
    .hit_o        (hit_o),
    .busy_o       (busy_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_data_i   (mem_data_i)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
`endif
  );

  localparam logic [63:0] DA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] DB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] DC = 64'hCCCC_CCCC_CCCC_CCCC;
  localparam logic [63:0] DD = 64'hDDDD_DDDD_DDDD_DDDD;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Combinational lookup that does not hold req_i across an edge.
  task automatic probe(
    input  logic [ADDR_SIZE-1:0]        pc,
    output logic                        h,
    output logic [ICACHE_LINE_SIZE-1:0] line
  );
    req_i = 1'b1;
    pc_i  = pc;
    #1;
    h     = hit_o;
    line  = inst_o;
    req_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni       = 1'b0;
    req_i        = 1'b0;
    pc_i         = '0;
    flush_i      = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_data_i   = '0;
    #12;
    rst_ni = 1'b1;
    tick();
  endtask

  // Miss on pc and serve the refill; flush_beat = -1 none, else beat number.
  task automatic refill(
    input logic [ADDR_SIZE-1:0] pc,
    input logic [63:0]          d0,
    input logic [63:0]          d1,
    input int                   gnt_wait,
    input int                   gap,
    input int                   flush_beat,
    input logic [ADDR_SIZE-1:0] other_pc
  );
    logic [ADDR_SIZE-1:0] la;
    logic [ADDR_SIZE+1:0] got;
    la    = pc & ~ADDR_SIZE'(15);
    req_i = 1'b1;
    pc_i  = pc;
    #1;
    n_cmp++;
    if (hit_o !== 1'b0) begin
      n_bad++;
      $display("FAIL miss_hit pc=%h: got %b expected 0", pc, hit_o);
    end
    n_cmp++;
    if (mem_req_o !== 1'b0) begin
      n_bad++;
      $display("FAIL req_early: got %b expected 0", mem_req_o);
    end
    tick();
    req_i = 1'b0;
    for (int i = 0; i <= gnt_wait; i++) begin
      got = {mem_req_o, busy_o, mem_addr_o};
      n_cmp++;
      if (got !== {2'b11, la}) begin
        n_bad++;
        $display("FAIL miss_req cyc=%0d: got %h expected %h",
                 i, got, {2'b11, la});
      end
      req_i = 1'b1;
      pc_i  = other_pc;
      #1;
      n_cmp++;
      if (hit_o !== 1'b0) begin
        n_bad++;
        $display("FAIL busy_hit cyc=%0d: got %b expected 0", i, hit_o);
      end
      req_i = 1'b0;
      if (i == gnt_wait) mem_gnt_i = 1'b1;
      tick();
    end
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_data_i   = d0;
    flush_i      = (flush_beat == 0);
    tick();
    mem_rvalid_i = 1'b0;
    flush_i      = 1'b0;
    repeat (gap) tick();
    mem_rvalid_i = 1'b1;
    mem_data_i   = d1;
    flush_i      = (flush_beat == 1);
    tick();
    mem_rvalid_i = 1'b0;
    flush_i      = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL refill_done busy: got %b expected 0", busy_o);
    end
  endtask

  task automatic test_reset();
    do_reset();
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({hit_o, busy_o, mem_req_o, mem_addr_o, inst_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_out: got %b%b%b %h %h expected all 0",
               hit_o, busy_o, mem_req_o, mem_addr_o, inst_o);
    end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_cold_miss_stall();
    logic                        h;
    logic [ICACHE_LINE_SIZE-1:0] l;
    refill(40'h1000, DA, DB, 5, 2, -1, 40'h1000);
    probe(40'h1004, h, l);
    n_cmp++;
    if (h !== 1'b1) begin
      n_bad++;
      $display("FAIL cold_hit: got %b expected 1", h);
    end
    n_cmp++;
    if (l !== {DB, DA}) begin
      n_bad++;
      $display("FAIL cold_line: got %h expected %h", l, {DB, DA});
    end
  endtask

  task automatic test_conflict();
    logic                        h;
    logic [ICACHE_LINE_SIZE-1:0] l;
    refill(40'h1400, DC, DD, 0, 0, -1, 40'h1000);
    probe(40'h1408, h, l);
    n_cmp++;
    if ({h, l} !== {1'b1, DD, DC}) begin
      n_bad++;
      $display("FAIL conflict_new: got %b %h expected 1 %h", h, l, {DD, DC});
    end
    probe(40'h1000, h, l);
    n_cmp++;
    if (h !== 1'b0) begin
      n_bad++;
      $display("FAIL conflict_evicted: got %b expected 0", h);
    end
    refill(40'h1010, DB, DC, 1, 1, -1, 40'h1400);
    probe(40'h1010, h, l);
    n_cmp++;
    if ({h, l} !== {1'b1, DC, DB}) begin
      n_bad++;
      $display("FAIL set1_line: got %b %h expected 1 %h", h, l, {DC, DB});
    end
    probe(40'h1400, h, l);
    n_cmp++;
    if (h !== 1'b1) begin
      n_bad++;
      $display("FAIL set0_kept: got %b expected 1", h);
    end
  endtask

  task automatic test_flush_mid_refill();
    logic                        h;
    logic [ICACHE_LINE_SIZE-1:0] l;
    refill(40'h1000, DD, DA, 0, 1, 0, 40'h1400);
    probe(40'h1000, h, l);
    n_cmp++;
    if (h !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_drop: got %b expected 0", h);
    end
    probe(40'h1010, h, l);
    n_cmp++;
    if (h !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_clear: got %b expected 0", h);
    end
  endtask

  task automatic test_flush_last_beat();
    logic                        h;
    logic [ICACHE_LINE_SIZE-1:0] l;
    refill(40'h2000, DA, DC, 0, 0, 1, 40'h2000);
    probe(40'h2000, h, l);
    n_cmp++;
    if (h !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_last: got %b expected 0", h);
    end
    refill(40'h2000, DC, DA, 0, 0, -1, 40'h2000);
    probe(40'h200c, h, l);
    n_cmp++;
    if ({h, l} !== {1'b1, DA, DC}) begin
      n_bad++;
      $display("FAIL refill_after_drop: got %b %h expected 1 %h",
               h, l, {DA, DC});
    end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    probe(40'h2000, h, l);
    n_cmp++;
    if (h !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_idle: got %b expected 0", h);
    end
  endtask

`ifdef ICACHE_PERF_EN
  task automatic test_perf();
    do_reset();
    n_cmp++;
    if ({hit_cnt_o, miss_cnt_o} !== 64'd0) begin
      n_bad++;
      $display("FAIL perf_reset: got %h %h expected 0 0", hit_cnt_o, miss_cnt_o);
    end
    refill(40'h3000, DA, DB, 0, 0, -1, 40'h3000);
    req_i = 1'b1;
    pc_i  = 40'h3000;
    repeat (3) tick();
    req_i = 1'b0;
    refill(40'h3010, DC, DD, 0, 0, -1, 40'h3000);
    n_cmp++;
    if ({hit_cnt_o, miss_cnt_o} !== {32'd3, 32'd2}) begin
      n_bad++;
      $display("FAIL perf_count: got %0d %0d expected 3 2", hit_cnt_o, miss_cnt_o);
    end
    force dut.hit_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.hit_cnt_q;
    req_i = 1'b1;
    pc_i  = 40'h3010;
    tick();
    req_i = 1'b0;
    n_cmp++;
    if (hit_cnt_o !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL perf_sat: got %h expected ffffffff", hit_cnt_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss_stall();
    test_conflict();
    test_flush_mid_refill();
    test_flush_last_beat();
`ifdef ICACHE_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1);
  end

endmodule
